// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the execute stage: aluop/alusel codes, divider states
// and the legacy reset/zero constants.
package ex_mdu_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Ops that only target HI/LO and never write the register file.
    function automatic logic hilo_only(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP)  ||
               (op == EXE_MTHI_OP) || (op == EXE_MTLO_OP);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// id/ex-to-mem bundle of the execute stage; master drives the instruction,
// slave (the execute stage) returns results and the stall request.
interface ex_mdu_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3
);
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [ALUOP_W-1:0]    aluop_i;
    logic [DATA_W-1:0]     reg1_data_i;
    logic [DATA_W-1:0]     reg2_data_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic [DATA_W-1:0]     hi_i;
    logic [DATA_W-1:0]     lo_i;
    logic                  annul_i;
    logic                  wreg_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  whilo_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output alusel_i, aluop_i, reg1_data_i, reg2_data_i, wd_i, wreg_i,
               hi_i, lo_i, annul_i,
        input  wreg_o, wd_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  alusel_i, aluop_i, reg1_data_i, reg2_data_i, wd_i, wreg_i,
               hi_i, lo_i, annul_i,
        output wreg_o, wd_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_mdu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed handled by
// magnitude division plus sign fix-up. result = {remainder, quotient}.
module div_iter
    import ex_mdu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
    logic                neg_quo_q, neg_rem_q;
    logic                op1_neg, op2_neg, ge;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     shifted, diff;

    assign op1_neg = signed_div & opdata1[DATA_W-1];
    assign op2_neg = signed_div & opdata2[DATA_W-1];
    assign abs1    = op1_neg ? (~opdata1 + DATA_W'(1)) : opdata1;
    assign abs2    = op2_neg ? (~opdata2 + DATA_W'(1)) : opdata2;

    // Trial subtraction; borrow out in the top bit means "does not fit".
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) state_q <= DIV_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start && !annul)
                          state_d = (opdata2 == '0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (annul)                             state_d = DIV_IDLE;
                      else if (count_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        result = '0;
        if (state_q == DIV_DONE && !annul) ready = 1'b1;
        result = {neg_rem_q ? (~rem_q + DATA_W'(1)) : rem_q,
                  neg_quo_q ? (~quo_q + DATA_W'(1)) : quo_q};
    end

    // Operand capture on accept, then one shift/subtract step per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: if (start && !annul) begin
                    count_q <= '0;
                    rem_q   <= '0;
                    if (opdata2 == '0) begin
                        quo_q     <= '0;
                        dvs_q     <= '0;
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                    end else begin
                        quo_q     <= abs1;
                        dvs_q     <= abs2;
                        neg_quo_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                    end
                end
                DIV_BUSY: if (!annul) begin
                    rem_q   <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                    quo_q   <= {quo_q[DATA_W-2:0], ge};
                    count_q <= count_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: same-cycle logic/shift/arith/move/multiply results, plus an
// iterative divider that stalls the pipeline until its HI/LO result is ready.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3
) (
    input  logic    clk,
    input  logic    rst,
    ex_mdu_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned PROD_W  = 2 * DATA_W;

    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  logic_res, shift_res, arith_res, move_res;
    logic [PROD_W-1:0]  mul_a, mul_b, product, div_result;
    logic               is_div, signed_div, div_ready, no_wreg;

    assign shamt      = bus.reg2_data_i[SHAMT_W-1:0];
    assign signed_div = (bus.aluop_i == ALUOP_W'(EXE_DIV_OP));
    assign is_div     = signed_div || (bus.aluop_i == ALUOP_W'(EXE_DIVU_OP));
    assign no_wreg    = hilo_only(8'(bus.aluop_i));

    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div),
        .signed_div (signed_div),
        .annul      (bus.annul_i),
        .opdata1    (bus.reg1_data_i),
        .opdata2    (bus.reg2_data_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    // Full-width product: sign- or zero-extend, keep the low 2*DATA_W bits.
    always_comb begin
        mul_a = {{DATA_W{1'b0}}, bus.reg1_data_i};
        mul_b = {{DATA_W{1'b0}}, bus.reg2_data_i};
        if (bus.aluop_i == ALUOP_W'(EXE_MULT_OP)) begin
            mul_a = {{DATA_W{bus.reg1_data_i[DATA_W-1]}}, bus.reg1_data_i};
            mul_b = {{DATA_W{bus.reg2_data_i[DATA_W-1]}}, bus.reg2_data_i};
        end
        product = mul_a * mul_b;
    end

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (bus.aluop_i)
            ALUOP_W'(EXE_OR_OP):   logic_res = bus.reg1_data_i | bus.reg2_data_i;
            ALUOP_W'(EXE_AND_OP):  logic_res = bus.reg1_data_i & bus.reg2_data_i;
            ALUOP_W'(EXE_XOR_OP):  logic_res = bus.reg1_data_i ^ bus.reg2_data_i;
            ALUOP_W'(EXE_NOR_OP):  logic_res = ~(bus.reg1_data_i | bus.reg2_data_i);
            ALUOP_W'(EXE_SLL_OP):  shift_res = bus.reg1_data_i << shamt;
            ALUOP_W'(EXE_SRL_OP):  shift_res = bus.reg1_data_i >> shamt;
            ALUOP_W'(EXE_SRA_OP):  shift_res = DATA_W'($signed(bus.reg1_data_i) >>> shamt);
            ALUOP_W'(EXE_ADDU_OP): arith_res = bus.reg1_data_i + bus.reg2_data_i;
            ALUOP_W'(EXE_SUBU_OP): arith_res = bus.reg1_data_i - bus.reg2_data_i;
            ALUOP_W'(EXE_SLT_OP):  arith_res = DATA_W'($signed(bus.reg1_data_i) < $signed(bus.reg2_data_i));
            ALUOP_W'(EXE_SLTU_OP): arith_res = DATA_W'(bus.reg1_data_i < bus.reg2_data_i);
            ALUOP_W'(EXE_MFHI_OP): move_res  = bus.hi_i;
            ALUOP_W'(EXE_MFLO_OP): move_res  = bus.lo_i;
            default: ;
        endcase
    end

    // Output routing; everything is held at zero while reset is asserted.
    always_comb begin
        bus.wreg_o     = 1'b0;
        bus.wd_o       = '0;
        bus.wdata_o    = DATA_W'(ZeroWord);
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
        if (rst != RstEnable) begin
            bus.wd_o   = REG_ADDR_W'(bus.wd_i);
            bus.wreg_o = bus.wreg_i & ~bus.annul_i & ~no_wreg;
            case (bus.alusel_i)
                ALUSEL_W'(EXE_RES_LOGIC): bus.wdata_o = logic_res;
                ALUSEL_W'(EXE_RES_SHIFT): bus.wdata_o = shift_res;
                ALUSEL_W'(EXE_RES_ARITH): bus.wdata_o = arith_res;
                ALUSEL_W'(EXE_RES_MOVE):  bus.wdata_o = move_res;
                default: ;
            endcase
            if (!bus.annul_i) begin
                case (bus.aluop_i)
                    ALUOP_W'(EXE_MTHI_OP): begin
                        bus.whilo_o = 1'b1;
                        bus.hi_o    = bus.reg1_data_i;
                        bus.lo_o    = bus.lo_i;
                    end
                    ALUOP_W'(EXE_MTLO_OP): begin
                        bus.whilo_o = 1'b1;
                        bus.hi_o    = bus.hi_i;
                        bus.lo_o    = bus.reg1_data_i;
                    end
                    ALUOP_W'(EXE_MULT_OP), ALUOP_W'(EXE_MULTU_OP): begin
                        bus.whilo_o = 1'b1;
                        {bus.hi_o, bus.lo_o} = product;
                    end
                    ALUOP_W'(EXE_DIV_OP), ALUOP_W'(EXE_DIVU_OP): begin
                        bus.whilo_o    = div_ready;
                        bus.stallreq_o = ~div_ready;
                        if (div_ready) {bus.hi_o, bus.lo_o} = div_result;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed and random ops against a
// plain-arithmetic reference model, divider latency, annul and async reset.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mdu_if #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) bus ();

    ex_mdu #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] comb_ops [17] = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP,
                                  EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_ADDU_OP,
                                  EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP,
                                  EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP,
                                  EXE_MULTU_OP};

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr, input logic an);
        bus.alusel_i    = sel;
        bus.aluop_i     = op;
        bus.reg1_data_i = a;
        bus.reg2_data_i = b;
        bus.wd_i        = wd;
        bus.wreg_i      = wr;
        bus.annul_i     = an;
    endtask

    function automatic logic [2:0] alusel_of(input logic [7:0] op);
        case (op)
            EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP:    return EXE_RES_LOGIC;
            EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:               return EXE_RES_SHIFT;
            EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP: return EXE_RES_ARITH;
            EXE_MFHI_OP, EXE_MFLO_OP:                         return EXE_RES_MOVE;
            default:                                          return EXE_RES_NOP;
        endcase
    endfunction

    // Reference model for single-cycle ops, straight from the op definitions.
    function automatic void model_comb(input logic [7:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] hi,
                                       input logic [31:0] lo, output logic [31:0] wdata,
                                       output logic whilo, output logic [31:0] ehi,
                                       output logic [31:0] elo, output logic wr_ok);
        longint sa, sb, sp;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        wdata = 0; whilo = 0; ehi = 0; elo = 0; wr_ok = 1;
        case (op)
            EXE_OR_OP:    wdata = a | b;
            EXE_AND_OP:   wdata = a & b;
            EXE_XOR_OP:   wdata = a ^ b;
            EXE_NOR_OP:   wdata = ~(a | b);
            EXE_SLL_OP:   wdata = a << b[4:0];
            EXE_SRL_OP:   wdata = a >> b[4:0];
            EXE_SRA_OP:   wdata = 32'(sa >>> b[4:0]);
            EXE_ADDU_OP:  wdata = a + b;
            EXE_SUBU_OP:  wdata = a - b;
            EXE_SLT_OP:   wdata = (sa < sb) ? 32'd1 : 32'd0;
            EXE_SLTU_OP:  wdata = (a < b) ? 32'd1 : 32'd0;
            EXE_MFHI_OP:  wdata = hi;
            EXE_MFLO_OP:  wdata = lo;
            EXE_MTHI_OP:  begin whilo = 1; ehi = a;  elo = lo; wr_ok = 0; end
            EXE_MTLO_OP:  begin whilo = 1; ehi = hi; elo = a;  wr_ok = 0; end
            EXE_MULT_OP:  begin sp = sa * sb; whilo = 1; {ehi, elo} = sp; wr_ok = 0; end
            EXE_MULTU_OP: begin up = {32'd0, a} * {32'd0, b}; whilo = 1; {ehi, elo} = up; wr_ok = 0; end
            default: ;
        endcase
    endfunction

    function automatic void model_div(input logic sgn, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] q,
                                      output logic [31:0] r);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin q = 0; r = 0; end
        else if (sgn) begin q = 32'(sa / sb); r = 32'(sa % sb); end
        else begin q = a / b; r = a % b; end
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit park);
        logic [31:0] q, r;
        int stalls = 0;
        int exp_stalls;
        bit done = 0;
        bit early_whilo = 0;
        model_div(sgn, a, b, q, r);
        exp_stalls = (b == 0) ? 1 : 33;
        @(posedge clk); #1;
        drive(EXE_RES_NOP, sgn ? EXE_DIV_OP : EXE_DIVU_OP, a, b, 5'd7, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (bus.stallreq_o === 1'b1) begin
                stalls++;
                if (bus.whilo_o !== 1'b0) early_whilo = 1;
            end else begin
                done = 1;
            end
        end
        checks++;
        if (!done || stalls != exp_stalls) begin
            failures++;
            $display("FAIL div_latency a=%h b=%h s=%0d got_stalls=%0d exp_stalls=%0d done=%0d", a, b, sgn, stalls, exp_stalls, done);
        end
        checks++;
        if (early_whilo) begin
            failures++;
            $display("FAIL div_early_whilo a=%h b=%h got=1 exp=0", a, b);
        end
        checks++;
        if (bus.whilo_o !== 1'b1 || bus.lo_o !== q || bus.hi_o !== r || bus.wreg_o !== 1'b0) begin
            failures++;
            $display("FAIL div_result a=%h b=%h s=%0d got whilo=%b hi=%h lo=%h wreg=%b exp whilo=1 hi=%h lo=%h wreg=0",
                     a, b, sgn, bus.whilo_o, bus.hi_o, bus.lo_o, bus.wreg_o, r, q);
        end
        if (park) begin
            @(posedge clk); #1;
            drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        bit bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s got=whilo_or_stall_seen exp=quiet", name);
        end
    endtask

    task automatic test_reset();
        bus.hi_i = 32'h1111_2222;
        bus.lo_i = 32'h3333_4444;
        drive(EXE_RES_LOGIC, EXE_OR_OP, 32'hFFFF_0000, 32'h0000_FFFF, 5'd9, 1'b1, 1'b0);
        #3;
        checks++;
        if ({bus.wreg_o, bus.wd_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
            failures++;
            $display("FAIL reset_or got wreg=%b wd=%h wdata=%h exp all zero", bus.wreg_o, bus.wd_o, bus.wdata_o);
        end
        drive(EXE_RES_NOP, EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 5'd9, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
            failures++;
            $display("FAIL reset_mult got whilo=%b hi=%h lo=%h exp all zero", bus.whilo_o, bus.hi_o, bus.lo_o);
        end
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed();
        @(posedge clk); #1;
        drive(EXE_RES_LOGIC, EXE_OR_OP, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'h0F0F_F0F0 || bus.wd_o !== 5'd3 || bus.wreg_o !== 1'b1) begin
            failures++;
            $display("FAIL or_plan got wdata=%h wd=%0d wreg=%b exp 0f0ff0f0 3 1", bus.wdata_o, bus.wd_o, bus.wreg_o);
        end
        drive(EXE_RES_SHIFT, EXE_SRA_OP, 32'h8000_0000, 32'd4, 5'd4, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra_plan got=%h exp=f8000000", bus.wdata_o);
        end
        drive(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'd1) begin
            failures++;
            $display("FAIL slt_plan got=%h exp=1", bus.wdata_o);
        end
        drive(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'd0) begin
            failures++;
            $display("FAIL sltu_plan got=%h exp=0", bus.wdata_o);
        end
        drive(EXE_RES_NOP, EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 5'd6, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFA || bus.whilo_o !== 1'b1 || bus.wreg_o !== 1'b0) begin
            failures++;
            $display("FAIL mult_plan got hi=%h lo=%h whilo=%b wreg=%b exp ffffffff fffffffa 1 0",
                     bus.hi_o, bus.lo_o, bus.whilo_o, bus.wreg_o);
        end
        drive(EXE_RES_LOGIC, 8'hFF, 32'h1234_5678, 32'h0F0F_0F0F, 5'd1, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'd0) begin
            failures++;
            $display("FAIL unknown_aluop got=%h exp=0", bus.wdata_o);
        end
        drive(3'b111, EXE_OR_OP, 32'h1234_5678, 32'h0F0F_0F0F, 5'd1, 1'b1, 1'b0);
        #2;
        checks++;
        if (bus.wdata_o !== 32'd0) begin
            failures++;
            $display("FAIL unknown_alusel got=%h exp=0", bus.wdata_o);
        end
    endtask

    task automatic test_random_comb();
        logic [7:0]  op;
        logic [31:0] a, b, hi, lo, ewd, ehi, elo;
        logic [4:0]  wd;
        logic        wr, an, ewhilo, wr_ok, ewreg;
        for (int i = 0; i < 80; i++) begin
            op = comb_ops[$urandom_range(16, 0)];
            a  = $urandom;
            b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
            hi = $urandom;
            lo = $urandom;
            wd = 5'($urandom);
            wr = 1'($urandom);
            an = (alusel_of(op) != EXE_RES_NOP) && ($urandom_range(7, 0) == 0);
            @(posedge clk); #1;
            bus.hi_i = hi;
            bus.lo_i = lo;
            drive(alusel_of(op), op, a, b, wd, wr, an);
            #2;
            model_comb(op, a, b, hi, lo, ewd, ewhilo, ehi, elo, wr_ok);
            ewreg = wr & ~an & wr_ok;
            checks++;
            if (bus.wdata_o !== ewd || bus.wreg_o !== ewreg || bus.wd_o !== wd || bus.whilo_o !== ewhilo) begin
                failures++;
                $display("FAIL rand_op op=%h a=%h b=%h got wdata=%h wreg=%b wd=%h whilo=%b exp %h %b %h %b",
                         op, a, b, bus.wdata_o, bus.wreg_o, bus.wd_o, bus.whilo_o, ewd, ewreg, wd, ewhilo);
            end
            if (ewhilo) begin
                checks++;
                if (bus.hi_o !== ehi || bus.lo_o !== elo) begin
                    failures++;
                    $display("FAIL rand_hilo op=%h a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                             op, a, b, bus.hi_o, bus.lo_o, ehi, elo);
                end
            end
        end
        @(posedge clk); #1;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_div();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
        run_div(1'b0, 32'd100, 32'd0, 1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_div(1'b1, 32'd5, 32'd0, 1);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1);
        for (int i = 0; i < 6; i++)
            run_div(1'($urandom), $urandom,
                    ($urandom_range(1, 0) == 0) ? 32'($urandom_range(300, 1)) : $urandom, 1);
    endtask

    task automatic test_back_to_back();
        run_div(1'b0, 32'd1000, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FC18, 32'd9, 0);
        run_div(1'b0, 32'd55, 32'd0, 1);
    endtask

    task automatic test_annul();
        @(posedge clk); #1;
        drive(EXE_RES_NOP, EXE_DIVU_OP, 32'd100, 32'd7, 5'd2, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        #2;
        checks++;
        if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0 || bus.wreg_o !== 1'b0) begin
            failures++;
            $display("FAIL annul_cycle got stall=%b whilo=%b wreg=%b exp 0 0 0", bus.stallreq_o, bus.whilo_o, bus.wreg_o);
        end
        @(posedge clk); #1;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        expect_quiet(40, "annul_no_write");
        run_div(1'b0, 32'd100, 32'd7, 1);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        drive(EXE_RES_LOGIC, EXE_DIVU_OP, 32'd1000, 32'd3, 5'd8, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.stallreq_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_reset got stall=%b exp=1", bus.stallreq_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.wreg_o, bus.wd_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
            failures++;
            $display("FAIL async_reset got stall=%b whilo=%b wd=%h exp all zero", bus.stallreq_o, bus.whilo_o, bus.wd_o);
        end
        @(posedge clk); #1;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        expect_quiet(40, "reset_abandons_div");
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.hi_i = '0;
        bus.lo_i = '0;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_random_comb();
        test_div();
        test_back_to_back();
        test_annul();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Parametrised execute stage with a multi-cycle multiply/divide unit; the successor to the single-op OR-only execute stage.
- Sits between the id/ex pipeline register and the mem stage.
- Computes logic, shift, add/sub/compare and HI/LO move results combinationally, and produces HI/LO writes for MULT/MULTU.
- Runs an iterative restoring divider for DIV/DIVU and raises a stall request to pipeline control while the divide is in progress.

Parameters:
- DATA_W, 32, operand/result width; must be even and at least 8.
- REG_ADDR_W, 5, destination register address width.
- ALUOP_W, 8, aluop encoding width.
- ALUSEL_W, 3, result-select encoding width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- alusel_i  in  ALUSEL_W  result class (LOGIC, SHIFT, ARITH, MOVE, NOP).
- aluop_i  in  ALUOP_W  operation code.
- reg1_data_i  in  DATA_W  operand A (dividend, shift source for register shifts).
- reg2_data_i  in  DATA_W  operand B (divisor; low log2(DATA_W) bits are the shift amount).
- wd_i  in  REG_ADDR_W  destination address.
- wreg_i  in  1  destination write enable.
- hi_i, lo_i  in  DATA_W each  current HI/LO, already forwarded upstream.
- annul_i  in  1  flush of the EX instruction; aborts a divide.
- wreg_o  out  1  write enable to mem.
- wd_o  out  REG_ADDR_W  destination address to mem.
- wdata_o  out  DATA_W  result to mem.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  DATA_W each  HI/LO write data.
- stallreq_o  out  1  stall request to pipeline control.

Behaviour:
- Reset:
  - While rst=1, all outputs are 0 and the FSM is IDLE.
  - Reset mid-divide abandons the divide with no HI/LO write.
- Combinational ops (same-cycle result):
  - OR, AND, XOR, NOR.
  - SLL, SRL, SRA: shift amount is reg2_data_i[log2(DATA_W)-1:0].
  - ADDU, SUBU: modulo 2^DATA_W.
  - SLT (signed) and SLTU (unsigned): result 1 or 0.
  - MFHI/MFLO: wdata_o = hi_i/lo_i.
  - MTHI: whilo_o=1, hi_o=reg1, lo_o=lo_i.
  - MTLO: whilo_o=1, lo_o=reg1, hi_o=hi_i.
  - MULT (signed) and MULTU: full 2*DATA_W-bit product, {hi_o,lo_o}=product, whilo_o=1, wreg_o=0.
- Result routing:
  - wd_o=wd_i.
  - wreg_o=wreg_i, except 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO and whenever annul_i=1.
  - wdata_o is selected by alusel_i; an unknown alusel_i or aluop_i gives 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - DIV/DIVU with annul_i=0 and divisor≠0: stallreq_o=1, latch operands (absolute values for DIV), count=0, next state BUSY.
    - Divisor=0: stallreq_o=1, next state DONE with quotient=0, remainder=0.
  - BUSY:
    - One restoring-division step per cycle; stallreq_o=1.
    - After DATA_W steps, next state DONE.
  - DONE:
    - stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder.
    - For DIV: quotient is negated if operand signs differ; remainder takes the dividend's sign.
    - Next state IDLE.
- Divider timing and abort:
  - Latency: DATA_W+2 cycles in EX for a nonzero divisor; 2 cycles for divisor 0.
  - Pipeline control holds the EX inputs stable while stallreq_o=1.
  - annul_i=1 in any state forces next state IDLE and whilo_o=0 that cycle; no HI/LO write occurs.
- Back-to-back divides: the FSM passes through IDLE for one cycle before accepting the next DIV.
- Edge cases:
  - Signed overflow (most-negative / -1) yields quotient=most-negative, remainder=0.
  - No exception is raised.

Decomposition:
- Shared package (existing defines file):
  - aluop codes: EXE_*_OP for OR, AND, XOR, NOR, SLL, SRL, SRA, ADDU, SUBU, SLT, SLTU, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
  - alusel codes: EXE_RES_*.
  - Divider state encoding.
  - RstEnable and ZeroWord.
- One sub-module: div_iter.
  - Contains the FSM, counter and restoring datapath.
  - Ports: clk, rst, start, signed_div, annul, opdata1, opdata2, result (2*DATA_W), ready.
- ex_mdu instantiates div_iter and holds all combinational ops.

Test Plan:
- OR 0x0000F0F0 | 0x0F0F0000, wd_i=3, wreg_i=1 -> wdata_o=0x0F0FF0F0, wd_o=3, wreg_o=1 in the same cycle.
- SRA reg1=0x80000000, reg2=4 -> 0xF8000000.
- SLT -1 vs 1 -> 1.
- SLTU with the same operands -> 0.
- MULT 0xFFFFFFFE (-2) × 3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, whilo_o=1, wreg_o=0.
- DIV -7 / 2 -> stallreq_o high for 33 cycles, then the DONE cycle gives lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1, stallreq_o=0.
- DIVU 100/0 -> DONE on cycle 2 with hi_o=lo_o=0.
- DIVU 100/7 with annul_i pulsed on BUSY cycle 10 -> FSM returns to IDLE next edge, no whilo_o pulse.
- Asserting rst on BUSY cycle 5 -> all outputs 0 immediately, asynchronously.
